// File: rtl/seg7_reader.sv
// Reads a multiplexed seven-segment bus back into BCD digits. Each digit must hold
// steady for STABLE_CYCLES samples before capture; a full scan is emitted as one frame.
module seg7_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [1:7]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    input  logic                    frame_ready,
    output logic                    frame_valid,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_err
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

    logic [1:7]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   en_q, en_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0]   shadow_err_q, shadow_err_d;
    logic [NUM_DIGITS-1:0]   seen_q, seen_d;
    logic                    valid_q, valid_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;

    logic                    one_hot;
    logic                    changed;
    logic                    capture;
    logic                    out_free;
    logic                    transfer;
    logic [4:0]              decoded;

    // Upper bit flags a pattern outside the 0-9 table; the nibble is then forced to F.
    function automatic logic [4:0] seg_to_bcd(input logic [1:7] seg);
        logic [4:0] r;
        case (seg)
            7'b1111110: r = 5'h00;
            7'b0110000: r = 5'h01;
            7'b1101101: r = 5'h02;
            7'b1111001: r = 5'h03;
            7'b0110011: r = 5'h04;
            7'b1011011: r = 5'h05;
            7'b1011111: r = 5'h06;
            7'b1110000: r = 5'h07;
            7'b1111111: r = 5'h08;
            7'b1111011: r = 5'h09;
            default:    r = 5'h1F;
        endcase
        return r;
    endfunction

    always_comb begin
        seg_d        = seg_in;
        en_d         = dig_en;
        one_hot      = $onehot(dig_en);
        changed      = (seg_in != seg_q) || (dig_en != en_q);
        decoded      = seg_to_bcd(seg_in);

        if (!one_hot) begin
            cnt_d = '0;
        end else if (changed) begin
            cnt_d = CW'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
        capture = (cnt_q == CNT_PRE) && (cnt_d == CNT_MAX);

        shadow_d     = shadow_q;
        shadow_err_d = shadow_err_q;
        seen_d       = seen_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (capture && dig_en[i]) begin
                shadow_d[4*i +: 4] = decoded[3:0];
                shadow_err_d[i]    = decoded[4];
                seen_d[i]          = 1'b1;
            end
        end

        // Transfer takes the shadow including any same-edge capture, so that capture is consumed.
        out_free = !valid_q || frame_ready;
        transfer = (&seen_q) && out_free;
        valid_d  = valid_q;
        digits_d = digits_q;
        err_d    = err_q;
        if (transfer) begin
            digits_d = shadow_d;
            err_d    = shadow_err_d;
            valid_d  = 1'b1;
            seen_d   = '0;
        end else if (valid_q && frame_ready) begin
            valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q        <= '0;
            en_q         <= '0;
            cnt_q        <= '0;
            shadow_q     <= '0;
            shadow_err_q <= '0;
            seen_q       <= '0;
            valid_q      <= 1'b0;
            digits_q     <= '0;
            err_q        <= '0;
        end else begin
            seg_q        <= seg_d;
            en_q         <= en_d;
            cnt_q        <= cnt_d;
            shadow_q     <= shadow_d;
            shadow_err_q <= shadow_err_d;
            seen_q       <= seen_d;
            valid_q      <= valid_d;
            digits_q     <= digits_d;
            err_q        <= err_d;
        end
    end

    assign frame_valid = valid_q;
    assign digits_out  = digits_q;
    assign digit_err   = err_q;

endmodule

// File: tb/tb_seg7_reader.sv
// Bench for seg7_reader: directed scans with a frame-level reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_seg7_reader;

    localparam int ND = 4;
    localparam int SC = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic [1:7]      seg_in = '0;
    logic [ND-1:0]   dig_en = '0;
    logic            frame_ready = 1'b0;
    logic            frame_valid;
    logic [4*ND-1:0] digits_out;
    logic [ND-1:0]   digit_err;

    int checks = 0;
    int errors = 0;

    logic [6:0] pat_tbl [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    int              run_len;
    logic [6:0]      prev_seg;
    logic [ND-1:0]   prev_en;
    int              sh_nib [ND];
    bit              sh_err [ND];
    bit              seen   [ND];
    logic            m_valid;
    logic [4*ND-1:0] m_digits;
    logic [ND-1:0]   m_err;

    seg7_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_in      (seg_in),
        .dig_en      (dig_en),
        .frame_ready (frame_ready),
        .frame_valid (frame_valid),
        .digits_out  (digits_out),
        .digit_err   (digit_err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int lookup(input logic [6:0] p);
        for (int k = 0; k < 10; k++) begin
            if (pat_tbl[k] == p) return k;
        end
        return 15;
    endfunction

    task automatic model_reset();
        run_len  = 0;
        prev_seg = '0;
        prev_en  = '0;
        for (int i = 0; i < ND; i++) begin
            sh_nib[i] = 0;
            sh_err[i] = 0;
            seen[i]   = 0;
        end
        m_valid  = 1'b0;
        m_digits = '0;
        m_err    = '0;
    endtask

    // A digit is taken when its one-hot sample has repeated for exactly SC consecutive edges.
    task automatic model_update();
        int  slot;
        int  val;
        bit  all_seen;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if ($countones(dig_en) != 1)                              run_len = 0;
        else if (seg_in == prev_seg && dig_en == prev_en)         run_len++;
        else                                                      run_len = 1;
        prev_seg = seg_in;
        prev_en  = dig_en;

        all_seen = 1;
        for (int i = 0; i < ND; i++) if (!seen[i]) all_seen = 0;

        slot = -1;
        if (run_len == SC) begin
            for (int i = 0; i < ND; i++) if (dig_en[i]) slot = i;
        end
        if (slot >= 0) begin
            val          = lookup(seg_in);
            sh_nib[slot] = val;
            sh_err[slot] = (val == 15);
            seen[slot]   = 1;
        end

        if (all_seen && (!m_valid || frame_ready)) begin
            for (int i = 0; i < ND; i++) begin
                m_digits[4*i +: 4] = 4'(sh_nib[i]);
                m_err[i]           = sh_err[i];
                seen[i]            = 0;
            end
            m_valid = 1'b1;
        end else if (m_valid && frame_ready) begin
            m_valid = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        check_output("cyc_frame_valid", 32'(frame_valid), 32'(m_valid));
        check_output("cyc_digits_out", 32'(digits_out), 32'(m_digits));
        check_output("cyc_digit_err", 32'(digit_err), 32'(m_err));
    end

    task automatic apply_stimulus(input logic [6:0] pat, input logic [ND-1:0] en,
                                  input logic rdy, input int cycles);
        repeat (cycles) begin
            seg_in      = pat;
            dig_en      = en;
            frame_ready = rdy;
            @(posedge clk);
            #1;
            model_update();
        end
    endtask

    task automatic scan_digit(input int idx, input int value, input logic rdy, input int cycles);
        logic [ND-1:0] en;
        en = ND'(1 << idx);
        apply_stimulus(pat_tbl[value], en, rdy, cycles);
    endtask

    task automatic check_zero_outputs(input string tag);
        check_output({tag, "_valid"}, 32'(frame_valid), 32'h0);
        check_output({tag, "_digits"}, 32'(digits_out), 32'h0);
        check_output({tag, "_err"}, 32'(digit_err), 32'h0);
    endtask

    task automatic do_reset();
        seg_in = '0;
        dig_en = '0;
        rst_n  = 1'b0;
        model_reset();
        #1;
        check_zero_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_zero_outputs("pulse_reset");
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        do_reset();

        // Basic scan, frame_ready high: frame appears one edge after digit 3 capture.
        scan_digit(0, 1, 1'b1, 10);
        scan_digit(1, 2, 1'b1, 10);
        scan_digit(2, 3, 1'b1, 10);
        scan_digit(3, 4, 1'b1, SC);
        check_output("basic_valid_at_capture", 32'(frame_valid), 32'h0);
        scan_digit(3, 4, 1'b1, 1);
        check_output("basic_valid", 32'(frame_valid), 32'h1);
        check_output("basic_digits", 32'(digits_out), 32'h4321);
        check_output("basic_err", 32'(digit_err), 32'h0);
        scan_digit(3, 4, 1'b1, 1);
        check_output("basic_valid_drop", 32'(frame_valid), 32'h0);
        check_output("basic_digits_hold", 32'(digits_out), 32'h4321);

        // Reset while outputs hold a frame.
        do_reset();

        // Glitch: digit 1 shown for only SC-1 cycles must not be captured.
        scan_digit(0, 1, 1'b0, 10);
        scan_digit(1, 7, 1'b0, SC - 1);
        scan_digit(2, 3, 1'b0, 10);
        scan_digit(3, 4, 1'b0, 10);
        check_output("glitch_no_frame", 32'(frame_valid), 32'h0);
        scan_digit(0, 1, 1'b0, 10);
        scan_digit(1, 2, 1'b0, 10);
        scan_digit(2, 3, 1'b0, 10);
        scan_digit(3, 4, 1'b0, 10);
        check_output("glitch_valid", 32'(frame_valid), 32'h1);
        check_output("glitch_digits", 32'(digits_out), 32'h4321);

        // Invalid pattern on digit 2.
        do_reset();
        scan_digit(0, 1, 1'b1, 10);
        scan_digit(1, 2, 1'b1, 10);
        apply_stimulus(7'b0000001, 4'b0100, 1'b1, 10);
        scan_digit(3, 4, 1'b1, SC + 1);
        check_output("invalid_valid", 32'(frame_valid), 32'h1);
        check_output("invalid_digits", 32'(digits_out), 32'h4F21);
        check_output("invalid_err", 32'(digit_err), 32'h4);
        scan_digit(3, 4, 1'b1, 1);

        // Backpressure: frame B waits behind frame A until ready rises.
        do_reset();
        scan_digit(0, 1, 1'b0, 10);
        scan_digit(1, 2, 1'b0, 10);
        scan_digit(2, 3, 1'b0, 10);
        scan_digit(3, 4, 1'b0, 10);
        check_output("bp_a_valid", 32'(frame_valid), 32'h1);
        check_output("bp_a_digits", 32'(digits_out), 32'h4321);
        scan_digit(0, 5, 1'b0, 10);
        scan_digit(1, 6, 1'b0, 10);
        scan_digit(2, 7, 1'b0, 10);
        scan_digit(3, 8, 1'b0, 10);
        check_output("bp_hold_valid", 32'(frame_valid), 32'h1);
        check_output("bp_hold_digits", 32'(digits_out), 32'h4321);
        scan_digit(3, 8, 1'b1, 1);
        check_output("bp_b_valid", 32'(frame_valid), 32'h1);
        check_output("bp_b_digits", 32'(digits_out), 32'h8765);
        scan_digit(3, 8, 1'b1, 1);
        check_output("bp_drain_valid", 32'(frame_valid), 32'h0);

        // Non-one-hot enables capture nothing, so digits 1-3 alone cannot form a frame.
        do_reset();
        apply_stimulus(pat_tbl[1], 4'b0011, 1'b0, 20);
        apply_stimulus(pat_tbl[1], 4'b0000, 1'b0, 20);
        scan_digit(1, 2, 1'b0, 10);
        scan_digit(2, 3, 1'b0, 10);
        scan_digit(3, 4, 1'b0, 10);
        check_output("bad_en_no_frame", 32'(frame_valid), 32'h0);

        // Reset mid-frame discards the partial scan.
        do_reset();
        scan_digit(0, 1, 1'b0, 10);
        scan_digit(1, 2, 1'b0, 10);
        scan_digit(2, 3, 1'b0, 10);
        pulse_reset();
        scan_digit(3, 4, 1'b0, 12);
        check_output("midreset_no_frame", 32'(frame_valid), 32'h0);
        check_output("midreset_digits", 32'(digits_out), 32'h0);

        @(posedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_reader.md
# seg7_reader

Captures a multiplexed seven-segment display bus and converts it back to BCD digits. It is the inverse of the team's BCD-to-segment decoder. It samples the active-high segment lines (abcdefg) together with one-hot digit enables, filters out scan transitions and glitches with a stability counter, and maps each stable pattern back to 0-9. Once every digit position has been captured, it presents one complete frame on a valid/ready output. Its role is to sit behind display pins or the display driver model, for loopback checking and for readback into the MIPS system.

## Interface
- NUM_DIGITS, 4, number of multiplexed digit positions (1-8)
- STABLE_CYCLES, 8, consecutive identical samples required before a digit is captured (2-255)

- clk  input  1  single system clock, all state on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- seg_in  input  [1:7]  segment lines; index 1 = a through 7 = g; 1 = lit
- dig_en  input  NUM_DIGITS  digit enables, active-high, expected one-hot
- frame_ready  input  1  consumer accepts frame when high with frame_valid
- frame_valid  output  1  digits_out/digit_err hold a complete frame
- digits_out  output  4*NUM_DIGITS  BCD of digit i in bits [4i+3:4i]
- digit_err  output  NUM_DIGITS  bit i set = digit i pattern not in 0-9 table

## Operation
- **Sample register:** the input sample register (seg_in, dig_en) loads every edge.
- **Stability counter:** cnt runs from 0 to STABLE_CYCLES.
  - Sample not one-hot (zero or multiple enables): cnt = 0.
  - Else if sample differs from previous sample: cnt = 1.
  - Else: cnt = min(cnt+1, STABLE_CYCLES).
- **Capture:** happens only on the edge where cnt moves from STABLE_CYCLES-1 to STABLE_CYCLES, so a held pattern is captured exactly once.
- **Pattern-to-BCD map (abcdefg):**
  - 1111110→0, 0110000→1, 1101101→2, 1111001→3, 0110011→4
  - 1011011→5, 1011111→6, 1110000→7, 1111111→8, 1111011→9
  - Any other pattern → 4'hF with the err bit set.
- **Shadow buffer:** a capture writes nibble and err bit into shadow slot i (i = enabled digit) and sets seen[i]. A re-capture of the same slot before the frame completes overwrites it (latest wins).
- **Frame transfer:** when seen is all-ones and the output register is free (frame_valid = 0, or frame_valid & frame_ready this cycle):
  - copy shadow to digits_out/digit_err;
  - set frame_valid;
  - clear seen.
- **Capture coinciding with transfer:** if a capture occurs on the same edge as the transfer, the captured value is the one written to the output and its seen bit stays cleared.
- **Backpressure:**
  - frame_valid & !frame_ready: digits_out, digit_err and frame_valid are held stable.
  - Capture continues into shadow during backpressure. A completed shadow frame waits with seen all-ones until the output frees.
  - frame_valid & frame_ready with no pending frame: frame_valid drops next edge.

## Timing
- **Reset values:** frame_valid = 0, digits_out = 0, digit_err = 0. Sample register, cnt, seen and shadow are also cleared, and any partial frame is discarded. Reset acts immediately when asserted, including mid-frame.
- **Capture latency:** inputs constant from before edge E1 are sampled at E1 (cnt = 1) and captured at edge E(STABLE_CYCLES).
- **Frame latency:** frame_valid rises at edge E(STABLE_CYCLES)+1 after the final missing digit's capture edge, provided the output is free.
- **Throughput:** one frame per full scan. Back-to-back frames are possible with frame_ready held high: frame_valid stays high and the data updates on the transfer edge.
- **Glitch rejection:** a pattern held for fewer than STABLE_CYCLES samples is never captured.
- **Non-one-hot enables:** a non-one-hot dig_en mid-hold restarts the count.

## Test plan
- **Reset:** assert rst_n = 0 mid-run → frame_valid, digits_out and digit_err read 0 immediately.
- **Basic scan:** STABLE_CYCLES = 8, frame_ready = 1. Scan dig_en 0001/0010/0100/1000 with patterns 0110000/1101101/1111001/0110011, each held 10 cycles → one frame, digits_out = 16'h4321, digit_err = 4'b0000, valid at capture edge +1 of digit 3.
- **Glitch rejection:** same scan, but digit 1 pattern held only 7 cycles before the next digit → no frame. Then complete a full scan → frame with digit 1 from the full scan.
- **Invalid pattern:** digit 2 shows 0000001, others valid (1, 2, _, 4) → digits_out = 16'h4F21, digit_err = 4'b0100.
- **Backpressure:** frame_ready = 0, frame A (4321) is presented, then scan frame B (8765) → outputs stay 4321. Raise frame_ready one cycle → next edge shows 8765 with frame_valid still 1. Next cycle with ready high → frame_valid = 0.
- **Bad enables / reset mid-frame:** dig_en = 0011 or 0000 for 20 cycles → no captures. Capture digits 0-2, pulse rst_n low, then capture only digit 3 → no frame.
